// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared types and default sizing for the regfile write-port arbiter.
// Holds the arbiter state codes and the parameter defaults.
package regfile_wport_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_INIT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_e;

  localparam int unsigned REG_NUM_DEF    = 32;
  localparam int unsigned ADDR_W_DEF     = 5;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned AUX_DEPTH_DEF  = 2;
  localparam int unsigned STARVE_LIM_DEF = 4;

endpackage

// File: rtl/regfile_wq_fifo.sv
// Aux write queue: entries of {live, addr, data} with address squash and
// two read-address hazard compare ports.
module regfile_wq_fifo
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = AUX_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic              ready,
  input  logic              pop,
  input  logic              squash_en,
  input  logic [ADDR_W-1:0] squash_addr,
  output logic              empty,
  output logic              head_live,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              hit1,
  output logic              hit2
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              live_r [DEPTH];
  logic [ADDR_W-1:0] addr_r [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_s;
  logic              pop_s;

  assign empty     = (count_r == CNT_W'(0));
  assign ready     = (count_r != CNT_W'(DEPTH));
  assign push_s    = push_valid && ready;
  assign pop_s     = pop && !empty;
  assign head_live = live_r[head_r];
  assign head_addr = addr_r[head_r];
  assign head_data = data_r[head_r];

  // Queue storage: squash first so a same-cycle push of the same address stays live.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        live_r[i] <= 1'b0;
        addr_r[i] <= '0;
        data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (squash_en && live_r[i] && (addr_r[i] == squash_addr)) begin
          live_r[i] <= 1'b0;
        end
      end
      if (pop_s) begin
        live_r[head_r] <= 1'b0;
        head_r         <= head_r + PTR_W'(1);
      end
      if (push_s) begin
        live_r[tail_r] <= (push_addr != '0);
        addr_r[tail_r] <= push_addr;
        data_r[tail_r] <= push_data;
        tail_r         <= tail_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Hazard compare against every live entry; r0 never hazards.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit1 = hit1 | (live_r[i] && (addr_r[i] == raddr1));
      hit2 = hit2 | (live_r[i] && (addr_r[i] == raddr2));
    end
    hit1 = hit1 && (raddr1 != '0);
    hit2 = hit2 && (raddr2 != '0);
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Owns the regfile write port: post-reset clear sweep, then WB-priority
// arbitration against a queued aux writer with starvation and hazard reporting.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned REG_NUM    = REG_NUM_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned AUX_DEPTH  = AUX_DEPTH_DEF,
  parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [ADDR_W-1:0] aux_waddr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              haz1,
  output logic              haz2,
  output logic              stall_req,
  output logic              init_busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int unsigned SCNT_W = $clog2(STARVE_LIM + 1);

  arb_state_e        state_r;
  logic [ADDR_W-1:0] init_cnt_r;
  logic [SCNT_W-1:0] starve_cnt_r;
  logic              rf_we_r;
  logic [ADDR_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;

  logic              run_s;
  logic              wb_write_s;
  logic              starve_s;
  logic              q_empty_s;
  logic              q_head_live_s;
  logic [ADDR_W-1:0] q_head_addr_s;
  logic [DATA_W-1:0] q_head_data_s;
  logic              q_hit1_s;
  logic              q_hit2_s;

  assign run_s      = (state_r == ARB_RUN);
  assign wb_write_s = wb_we && (wb_waddr != '0);
  assign starve_s   = (starve_cnt_r >= SCNT_W'(STARVE_LIM));
  assign init_busy  = !run_s;
  assign stall_req  = init_busy | starve_s;
  assign haz1       = run_s && q_hit1_s;
  assign haz2       = run_s && q_hit2_s;
  assign rf_we      = rf_we_r;
  assign rf_waddr   = rf_waddr_r;
  assign rf_wdata   = rf_wdata_r;

  regfile_wq_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (AUX_DEPTH)
  ) u_wq (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (aux_valid),
    .push_addr   (aux_waddr),
    .push_data   (aux_wdata),
    .ready       (aux_ready),
    .pop         (run_s && !wb_write_s),
    .squash_en   (run_s && wb_write_s),
    .squash_addr (wb_waddr),
    .empty       (q_empty_s),
    .head_live   (q_head_live_s),
    .head_addr   (q_head_addr_s),
    .head_data   (q_head_data_s),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .hit1        (q_hit1_s),
    .hit2        (q_hit2_s)
  );

  // Arbiter FSM: clear sweep, then WB-over-queue selection into the output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ARB_INIT;
      init_cnt_r   <= ADDR_W'(1);
      starve_cnt_r <= '0;
      rf_we_r      <= 1'b0;
      rf_waddr_r   <= '0;
      rf_wdata_r   <= '0;
    end else begin
      case (state_r)
        ARB_INIT: begin
          rf_we_r    <= 1'b1;
          rf_waddr_r <= init_cnt_r;
          rf_wdata_r <= '0;
          init_cnt_r <= init_cnt_r + ADDR_W'(1);
          if (init_cnt_r == ADDR_W'(REG_NUM - 1)) begin
            state_r <= ARB_RUN;
          end
        end
        ARB_RUN: begin
          if (wb_write_s) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= wb_waddr;
            rf_wdata_r <= wb_wdata;
          end else if (!q_empty_s && q_head_live_s) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= q_head_addr_s;
            rf_wdata_r <= q_head_data_s;
          end else begin
            rf_we_r <= 1'b0;
          end
          // Starvation counts only while a live head loses to WB; any pop clears it.
          if (!q_empty_s && !wb_write_s) begin
            starve_cnt_r <= '0;
          end else if (!q_empty_s && q_head_live_s && !starve_s) begin
            starve_cnt_r <= starve_cnt_r + SCNT_W'(1);
          end
        end
        default: begin
          state_r <= ARB_INIT;
          rf_we_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
